// File: rtl/analog_stick_pkg.sv
// analog_stick_pkg: shared types and the CENTER default helper (ANALOG_STICK_ACCEL_EN selects hold-to-accelerate)
package analog_stick_pkg;
  typedef enum logic {IDLE, CONV} adc_state_t;
  typedef enum logic [1:0] {NONE, NEG, POS} dir_t;
  function automatic int center_of(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
endpackage

// File: rtl/analog_axis.sv
// analog_axis: one saturating stick axis; ports clk6m/reset_n, i_tick frame pulse, i_neg_n/i_pos_n switches, o_pos position; ANALOG_STICK_ACCEL_EN adds step growth
module analog_axis
  import analog_stick_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CENTER       = 127,
  parameter int MAX_STEP     = 4,
  parameter int ACCEL_FRAMES = 8
) (
  input  logic             clk6m,
  input  logic             reset_n,
  input  logic             i_tick,
  input  logic             i_neg_n,
  input  logic             i_pos_n,
  output logic [WIDTH-1:0] o_pos
);
  localparam logic [WIDTH-1:0] C = WIDTH'(CENTER);
  dir_t             w_dir;
  logic [WIDTH:0]   w_step;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_pos_nxt;
  logic [WIDTH-1:0] r_pos;
  assign w_dir = (!i_neg_n && i_pos_n) ? NEG : (i_neg_n && !i_pos_n) ? POS : NONE;
`ifdef ANALOG_STICK_ACCEL_EN
  localparam int SW = $clog2(MAX_STEP + 1);
  localparam int CW = $clog2(ACCEL_FRAMES + 1);
  localparam logic [SW-1:0] MAXS = SW'(MAX_STEP);
  localparam logic [CW-1:0] AF = CW'(ACCEL_FRAMES);
  dir_t          r_dir_last;
  logic [SW-1:0] r_step;
  logic [SW-1:0] w_step_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_same;
  logic          w_wrap;
  assign w_same     = (w_dir != NONE) && (w_dir == r_dir_last);
  assign w_cnt_inc  = r_cnt + CW'(1);
  assign w_wrap     = w_same && (w_cnt_inc == AF);
  // the step chosen on this tick is also the one applied to the position on this tick
  assign w_step_nxt = !w_same ? SW'(1) : (w_wrap && (r_step < MAXS)) ? r_step + SW'(1) : r_step;
  assign w_cnt_nxt  = (w_same && !w_wrap) ? w_cnt_inc : '0;
  assign w_step     = (WIDTH+1)'(w_step_nxt);
  always_ff @(posedge clk6m or negedge reset_n) begin
    if (!reset_n) begin
      r_dir_last <= NONE;
      r_step     <= SW'(1);
      r_cnt      <= '0;
    end else if (i_tick) begin
      r_dir_last <= w_dir;
      r_step     <= w_step_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end
`else
  assign w_step = (WIDTH+1)'(1);
`endif
  assign w_sum     = {1'b0, r_pos} + w_step;
  assign w_pos_nxt = (w_dir == NEG) ? ((w_step > {1'b0, r_pos}) ? '0 : r_pos - w_step[WIDTH-1:0]) :
                     (w_dir == POS) ? (w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0]) :
                     (r_pos > C) ? r_pos - WIDTH'(1) : (r_pos < C) ? r_pos + WIDTH'(1) : r_pos;
  always_ff @(posedge clk6m or negedge reset_n) begin
    if (!reset_n) r_pos <= C;
    else if (i_tick) r_pos <= w_pos_nxt;
  end
  assign o_pos = r_pos;
endmodule

// File: rtl/analog_stick_emu.sv
// analog_stick_emu: joystick axes plus ADC model; ports clk6m/reset_n, vblank, js_neg/js_pos, a/wr_n/rd_n CPU side, data_out/busy/pos_out; ANALOG_STICK_ACCEL_EN enables acceleration
module analog_stick_emu
  import analog_stick_pkg::*;
#(
  parameter int NUM_AXES     = 4,
  parameter int WIDTH        = 8,
  parameter int CENTER       = center_of(WIDTH),
  parameter int MAX_STEP     = 4,
  parameter int ACCEL_FRAMES = 8,
  parameter int CONV_CYCLES  = 16,
  parameter int ADDR_W       = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1
) (
  input  logic                      clk6m,
  input  logic                      reset_n,
  input  logic                      vblank,
  input  logic [NUM_AXES-1:0]       js_neg,
  input  logic [NUM_AXES-1:0]       js_pos,
  input  logic [ADDR_W-1:0]         a,
  input  logic                      wr_n,
  input  logic                      rd_n,
  output logic [15:0]               data_out,
  output logic                      busy,
  output logic [NUM_AXES*WIDTH-1:0] pos_out
);
  localparam int CCW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [WIDTH-1:0] C = WIDTH'(CENTER);
  // padded to the full address space so unpopulated channels read CENTER without a range check
  logic [WIDTH-1:0] w_pos [2**ADDR_W];
  logic             r_vblank_q;
  logic             r_tick;
  logic             r_wr_q;
  adc_state_t       r_state;
  logic [ADDR_W-1:0] r_chan;
  logic [CCW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_result;
  for (genvar g = 0; g < 2**ADDR_W; g++) begin : g_ax
    if (g < NUM_AXES) begin : g_on
      analog_axis #(
        .WIDTH(WIDTH), .CENTER(CENTER), .MAX_STEP(MAX_STEP), .ACCEL_FRAMES(ACCEL_FRAMES)
      ) u_axis (
        .clk6m(clk6m), .reset_n(reset_n), .i_tick(r_tick),
        .i_neg_n(js_neg[g]), .i_pos_n(js_pos[g]), .o_pos(w_pos[g])
      );
      assign pos_out[g*WIDTH +: WIDTH] = w_pos[g];
    end else begin : g_off
      assign w_pos[g] = C;
    end
  end
  always_ff @(posedge clk6m or negedge reset_n) begin
    if (!reset_n) begin
      r_vblank_q <= 1'b0;
      r_tick     <= 1'b0;
      r_wr_q     <= 1'b1;
      r_state    <= IDLE;
      r_chan     <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      busy       <= 1'b0;
      data_out   <= '0;
    end else begin
      r_vblank_q <= vblank;
      r_tick     <= vblank & ~r_vblank_q;
      r_wr_q     <= wr_n;
      if (!rd_n) data_out <= 16'(r_result);
      if (r_state == IDLE) begin
        if (!wr_n && r_wr_q) begin
          r_chan  <= a;
          r_cnt   <= CCW'(CONV_CYCLES - 1);
          busy    <= 1'b1;
          r_state <= CONV;
        end
      end else if (r_cnt == '0) begin
        r_result <= w_pos[r_chan];
        busy     <= 1'b0;
        r_state  <= IDLE;
      end else begin
        r_cnt <= r_cnt - CCW'(1);
      end
    end
  end
endmodule

// File: tb/tb_analog_stick_emu.sv
// tb_analog_stick_emu: directed checks of axis motion, saturation, release, ADC timing, reads and reset abort
module tb_analog_stick_emu;
  localparam int N = 3;
  localparam int W = 8;
`ifdef ANALOG_STICK_ACCEL_EN
  localparam int P1 = 163, A0_FR = 43, A0_V = 3;
`else
  localparam int P1 = 147, A0_FR = 126, A0_V = 1;
`endif
  logic           clk6m = 1'b0;
  logic           reset_n = 1'b0;
  logic           vblank = 1'b0;
  logic           wr_n = 1'b1;
  logic           rd_n = 1'b1;
  logic [N-1:0]   js_neg = '1;
  logic [N-1:0]   js_pos = '1;
  logic [1:0]     a = '0;
  logic [15:0]    data_out;
  logic           busy;
  logic [N*W-1:0] pos_out;
  int             n_chk = 0;
  int             n_err = 0;
  int             bc;
  always #5 clk6m = ~clk6m;
  analog_stick_emu #(.NUM_AXES(N)) dut (
    .clk6m(clk6m), .reset_n(reset_n), .vblank(vblank), .js_neg(js_neg), .js_pos(js_pos),
    .a(a), .wr_n(wr_n), .rd_n(rd_n), .data_out(data_out), .busy(busy), .pos_out(pos_out)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] pos(input int i);
    return pos_out[i*W +: W];
  endfunction
  task automatic frames(input int n);
    repeat (n) begin
      @(negedge clk6m) vblank = 1'b1;
      @(negedge clk6m);
      @(negedge clk6m) vblank = 1'b0;
      @(negedge clk6m);
    end
  endtask
  task automatic convert(input logic [1:0] ch, output int cnt);
    cnt = 0;
    @(negedge clk6m);
    a    = ch;
    wr_n = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk6m);
      cnt += int'(busy);
      wr_n = (i == 4) ? 1'b0 : 1'b1;
    end
  endtask
  task automatic read_out();
    @(negedge clk6m) rd_n = 1'b0;
    @(negedge clk6m) rd_n = 1'b1;
  endtask
  initial begin
    repeat (3) @(negedge clk6m);
    reset_n = 1'b1;
    check("rst_pos", pos_out, {N{8'd127}});
    check("rst_busy", busy, 0);
    check("rst_data", data_out, 0);
    frames(3);
    check("idle_pos", pos_out, {N{8'd127}});
    js_pos[1] = 1'b0;
    frames(20);
    check("ax1_up", pos(1), P1);
    js_pos[1] = 1'b1;
    convert(2'd1, bc);
    check("busy_len", bc, 16);
    check("pre_read", data_out, 0);
    read_out();
    check("rd_ax1", data_out, P1);
    frames(1);
    check("rel_1", pos(1), P1 - 1);
    frames(P1 - 128);
    check("rel_ctr", pos(1), 127);
    frames(3);
    check("rel_hold", pos(1), 127);
    js_neg[0] = 1'b0;
    frames(A0_FR);
    check("ax0_near", pos(0), A0_V);
    frames(1);
    check("ax0_sat", pos(0), 0);
    frames(2);
    check("ax0_hold", pos(0), 0);
    js_neg[0] = 1'b1;
    js_pos[2] = 1'b0;
    frames(140);
    check("ax2_sat", pos(2), 255);
    js_neg[2] = 1'b0;
    frames(1);
    check("ax2_both", pos(2), 254);
    js_neg[2] = 1'b1;
    js_pos[2] = 1'b1;
    check("ax1_indep", pos(1), 127);
    convert(2'd3, bc);
    read_out();
    check("rd_oor", data_out, 16'h007F);
    convert(2'd2, bc);
    read_out();
    check("rd_ax2", data_out, 16'h00FE);
    @(negedge clk6m);
    a    = 2'd2;
    wr_n = 1'b0;
    @(negedge clk6m) wr_n = 1'b1;
    repeat (6) @(negedge clk6m);
    check("mid_busy", busy, 1);
    #1 reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_pos", pos_out, {N{8'd127}});
    check("abort_data", data_out, 0);
    @(negedge clk6m) reset_n = 1'b1;
    repeat (20) @(negedge clk6m);
    read_out();
    check("abort_result", data_out, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
